// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive rising edges of pulse_in, with a one-cycle
// period strobe and a sticky timeout. Define PULSE_METER_SYNC_EN to add a 2-flop input synchronizer.
module pulse_period_meter #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] TIMEOUT = 32'd100000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             p_prev_q, p_prev_d;
  logic             p_cur;
  logic             rise;

`ifdef PULSE_METER_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = pulse_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign p_cur = sync2_q;
`else
  assign p_cur = pulse_in;
`endif

  // The input stage runs regardless of en, so re-enabling with pulse_in high is not a rise.
  assign p_prev_d = p_cur;
  assign rise     = p_cur & ~p_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = WIDTH'(1);
          end
        end
        MEASURE: begin
          // A rise landing on the timeout cycle still counts as a valid period of TIMEOUT.
          if (rise) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = WIDTH'(1);
          end else if (cnt_q == TIMEOUT) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      p_prev_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      p_prev_q  <= p_prev_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: one instance with TIMEOUT=8 for the timeout and
// boundary cases, one with TIMEOUT=100 for wide-pulse periods longer than 8.
module tb_pulse_period_meter;
  localparam int W = 16;
`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pulse_in = 1'b0;

  logic [W-1:0] per_a, per_w;
  logic         val_a, val_w, to_a, to_w, busy_a, busy_w;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_a_q[$];
  logic [W-1:0] got_w_q[$];
  int           got_a_t[$];
  int           got_w_t[$];

  always #5 clk = ~clk;

  pulse_period_meter #(.WIDTH(W), .TIMEOUT(16'd8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
    .period_out(per_a), .period_valid(val_a), .timeout(to_a), .busy(busy_a)
  );

  pulse_period_meter #(.WIDTH(W), .TIMEOUT(16'd100)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
    .period_out(per_w), .period_valid(val_w), .timeout(to_w), .busy(busy_w)
  );

  // Strobe monitor: records every reported period with its cycle stamp.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (val_a) begin
      got_a_q.push_back(per_a);
      got_a_t.push_back(cyc);
    end
    if (val_w) begin
      got_w_q.push_back(per_w);
      got_w_t.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic train(input int period, input int width, input int n_edges);
    for (int i = 0; i < n_edges; i++) begin
      pulse_in = 1'b1;
      tick(width);
      pulse_in = 1'b0;
      tick(period - width);
    end
  endtask

  task automatic go_idle();
    en = 1'b0;
    tick(2);
    en = 1'b1;
  endtask

  task automatic clear_all();
    exp_q.delete();
    got_a_q.delete();
    got_a_t.delete();
    got_w_q.delete();
    got_w_t.delete();
  endtask

  task automatic check_stream(input string tag, input bit sel_w, input int spacing);
    logic [W-1:0] gq[$];
    int           gt[$];
    if (sel_w) begin
      gq = got_w_q;
      gt = got_w_t;
    end else begin
      gq = got_a_q;
      gt = got_a_t;
    end
    check_eq({tag, " strobes"}, gq.size(), exp_q.size());
    for (int i = 0; i < gq.size() && i < exp_q.size(); i++) begin
      check_eq({tag, " period"}, 32'(gq[i]), 32'(exp_q[i]));
      if (i > 0) check_eq({tag, " spacing"}, gt[i] - gt[i-1], spacing);
    end
  endtask

  initial begin
    // Reset state
    en = 1'b1;
    tick(3);
    check_eq("rst period_out", 32'(per_a), 0);
    check_eq("rst valid", 32'(val_a), 0);
    check_eq("rst timeout", 32'(to_a), 0);
    check_eq("rst busy", 32'(busy_a), 0);
    rst_n = 1'b1;
    tick(1);

    // First edge only arms
    clear_all();
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(LAT + 1);
    check_eq("arm busy", 32'(busy_a), 1);
    check_eq("arm valid", 32'(val_a), 0);
    check_eq("arm period_out", 32'(per_a), 0);
    check_eq("arm strobes", got_a_q.size(), 0);
    go_idle();

    // Steady stream, P=5
    clear_all();
    exp_q = '{16'd5, 16'd5, 16'd5};
    train(5, 1, 4);
    tick(LAT + 1);
    check_stream("steady", 1'b0, 5);
    check_eq("steady timeout", 32'(to_a), 0);
    go_idle();

    // Back-to-back, P=2
    clear_all();
    exp_q = '{16'd2, 16'd2, 16'd2};
    train(2, 1, 4);
    tick(LAT);
    check_stream("p2", 1'b0, 2);
    go_idle();

    // Timeout after one edge and silence
    clear_all();
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(LAT + 6);
    check_eq("pre-timeout", 32'(to_a), 0);
    check_eq("pre-timeout busy", 32'(busy_a), 1);
    tick(1);
    check_eq("timeout set", 32'(to_a), 1);
    check_eq("timeout busy", 32'(busy_a), 0);
    check_eq("timeout period_out", 32'(per_a), 2);
    check_eq("timeout strobes", got_a_q.size(), 0);

    // Recovery clears timeout
    clear_all();
    exp_q = '{16'd4};
    train(4, 1, 2);
    tick(LAT);
    check_stream("recover", 1'b0, 4);
    check_eq("recover timeout", 32'(to_a), 0);
    go_idle();

    // Rise exactly at TIMEOUT wins
    clear_all();
    exp_q = '{16'd8};
    train(8, 1, 2);
    check_stream("boundary", 1'b0, 8);
    check_eq("boundary timeout", 32'(to_a), 0);
    go_idle();
    check_eq("en over timeout", 32'(to_a), 0);

    // en dropped mid-period
    clear_all();
    exp_q = '{16'd6};
    train(6, 1, 2);
    check_stream("pre-en", 1'b0, 6);
    clear_all();
    en = 1'b0;
    tick(2);
    en = 1'b1;
    check_eq("en-drop strobes", got_a_q.size(), 0);
    check_eq("en-drop period_out", 32'(per_a), 6);
    check_eq("en-drop busy", 32'(busy_a), 0);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(4);
    check_eq("rearm strobes", got_a_q.size(), 0);
    check_eq("rearm period_out", 32'(per_a), 6);
    check_eq("rearm busy", 32'(busy_a), 1);
    exp_q = '{16'd5};
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(LAT + 1);
    check_stream("after-en", 1'b0, 5);

    // Asynchronous reset mid-period
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    check_eq("mid-rst period_out", 32'(per_a), 0);
    check_eq("mid-rst valid", 32'(val_a), 0);
    check_eq("mid-rst timeout", 32'(to_a), 0);
    check_eq("mid-rst busy", 32'(busy_a), 0);
    tick(2);
    rst_n = 1'b1;
    clear_all();
    exp_q = '{16'd4, 16'd4};
    train(4, 1, 3);
    tick(LAT);
    check_stream("post-rst", 1'b0, 4);
    go_idle();

    // Wide pulses, P=10, on the long-timeout instance
    clear_all();
    exp_q = '{16'd10, 16'd10};
    train(10, 3, 3);
    tick(LAT);
    check_stream("wide", 1'b1, 10);
    check_eq("wide timeout", 32'(to_w), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
